// File: rtl/bitrev_reorder.sv
`timescale 1ns/1ps
// Purpose: reorders FFT output from bit-reversed index order to natural order via ping-pong banks.
// Latency: first sample of a frame appears 2 edges after the edge that accepts that frame's last sample.
// Backpressure: none; every valid input is accepted and the output cannot be stalled.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   data_in         - complex sample {real, imag}, float_len bits each
//   data_in_valid   - data_in is valid this cycle
//   data_out        - reordered sample, registered, forced to 0 when not valid
//   data_out_valid  - data_out is valid this cycle, registered
//   data_out_sop    - (only with BITREV_FRAME_START_EN) high on the first sample of each frame
//
// Optional feature macro: BITREV_FRAME_START_EN adds the data_out_sop output.
module bitrev_reorder #(
    parameter int float_len     = 32,
    parameter int bram_addr_len = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [float_len*2-1:0] data_in,
    input  logic                   data_in_valid,
    output logic [float_len*2-1:0] data_out,
    output logic                   data_out_valid
`ifdef BITREV_FRAME_START_EN
    ,
    output logic                   data_out_sop
`endif
);

    localparam int N  = 1 << bram_addr_len;
    localparam int DW = float_len * 2;

    typedef logic [bram_addr_len-1:0] addr_t;
    typedef enum logic { RD_IDLE, RD_READ } rd_state_t;

    localparam addr_t LAST_ADDR = addr_t'(N - 1);

    function automatic addr_t bitrev(input addr_t a);
        addr_t r;
        for (int i = 0; i < bram_addr_len; i++) begin
            r[i] = a[bram_addr_len-1-i];
        end
        return r;
    endfunction

    // Two banks of N samples; contents need no reset.
    logic [DW-1:0] bank_mem [2][N];

    addr_t         wr_cnt_q, wr_cnt_d;
    logic          wr_sel_q, wr_sel_d;
    addr_t         rd_cnt_q, rd_cnt_d;
    logic          rd_sel_q, rd_sel_d;
    logic [1:0]    full_q, full_d;
    rd_state_t     state_q, state_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          data_out_valid_q, data_out_valid_d;
`ifdef BITREV_FRAME_START_EN
    logic          sop_q, sop_d;
`endif

    logic [DW-1:0] rd_dat;
    assign rd_dat = bank_mem[rd_sel_q][bitrev(rd_cnt_q)];

    always_comb begin
        wr_cnt_d         = wr_cnt_q;
        wr_sel_d         = wr_sel_q;
        rd_cnt_d         = rd_cnt_q;
        rd_sel_d         = rd_sel_q;
        full_d           = full_q;
        state_d          = state_q;
        data_out_d       = '0;
        data_out_valid_d = 1'b0;
`ifdef BITREV_FRAME_START_EN
        sop_d            = 1'b0;
`endif

        // Reader: the clear of full[rd_sel] is applied before the writer's set
        // so both land on the same edge (they always target different banks).
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    state_d = RD_READ;
                end
            end
            RD_READ: begin
                data_out_d       = rd_dat;
                data_out_valid_d = 1'b1;
`ifdef BITREV_FRAME_START_EN
                sop_d            = (rd_cnt_q == '0);
`endif
                rd_cnt_d = rd_cnt_q + addr_t'(1);
                if (rd_cnt_q == LAST_ADDR) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = ~rd_sel_q;
                    // Continue straight into the other bank when it is already
                    // complete, which keeps gap-free input gap-free at the output.
                    if (!full_q[~rd_sel_q]) begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        // Writer: a bank is only marked full once all N samples are stored.
        if (data_in_valid) begin
            wr_cnt_d = wr_cnt_q + addr_t'(1);
            if (wr_cnt_q == LAST_ADDR) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q         <= '0;
            wr_sel_q         <= 1'b0;
            rd_cnt_q         <= '0;
            rd_sel_q         <= 1'b0;
            full_q           <= '0;
            state_q          <= RD_IDLE;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
`ifdef BITREV_FRAME_START_EN
            sop_q            <= 1'b0;
`endif
        end else begin
            wr_cnt_q         <= wr_cnt_d;
            wr_sel_q         <= wr_sel_d;
            rd_cnt_q         <= rd_cnt_d;
            rd_sel_q         <= rd_sel_d;
            full_q           <= full_d;
            state_q          <= state_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
`ifdef BITREV_FRAME_START_EN
            sop_q            <= sop_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (data_in_valid) begin
            bank_mem[wr_sel_q][wr_cnt_q] <= data_in;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
`ifdef BITREV_FRAME_START_EN
    assign data_out_sop   = sop_q;
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for bitrev_reorder with a queue-based scoreboard.
// Latency: checks first output of each burst lands 2 edges after the frame's last input edge.
// Backpressure: none in the DUT; the bench drives one sample per cycle or with gaps.
module tb_bitrev_reorder;

    localparam int FL = 32;
    localparam int DW = FL * 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
`ifdef BITREV_FRAME_START_EN
    logic          data_out_sop;
`endif

    bitrev_reorder #(.float_len(FL), .bram_addr_len(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
`ifdef BITREV_FRAME_START_EN
        ,
        .data_out_sop   (data_out_sop)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    typedef struct {
        logic [DW-1:0] dat;
        bit            sop;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   len_q[$];

    // Bit-reversed visiting order for N=8, written out by hand.
    int order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic logic [DW-1:0] smp(input int k);
        return {k[31:0], 32'h0};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none at edge %0d", name, edge_cnt);
    endtask

    task automatic push_frame(input int base, input int n_emit);
        for (int i = 0; i < n_emit; i++) begin
            exp_t e;
            e.dat = smp(base + order[i]);
            e.sop = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the input idle.
    task automatic send(input int k);
        data_in       = smp(k);
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in       = '0;
        data_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: samples outputs on the falling edge, away from the active edge.
    bit prev_vld = 1'b0;
    int run_len  = 0;

    always @(negedge clk) begin
        if (data_out_valid) begin
            if (!prev_vld) begin
                if (start_q.size() == 0) fail_now("burst_start_unexpected");
                else check("burst_start_edge", DW'(edge_cnt), DW'(start_q.pop_front()));
                run_len = 0;
            end
            run_len++;
            if (exp_q.size() == 0) begin
                fail_now("output_unexpected");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data", data_out, e.dat);
`ifdef BITREV_FRAME_START_EN
                check("sop", DW'(data_out_sop), DW'(e.sop));
`endif
            end
        end else begin
            check("idle_data_zero", data_out, '0);
`ifdef BITREV_FRAME_START_EN
            check("idle_sop_zero", DW'(data_out_sop), '0);
`endif
            if (prev_vld) begin
                if (len_q.size() == 0) fail_now("burst_end_unexpected");
                else check("burst_length", DW'(run_len), DW'(len_q.pop_front()));
            end
        end
        prev_vld = data_out_valid;
    end

    initial begin
        // Reset state
        #12;
        check("reset_valid", DW'(data_out_valid), '0);
        check("reset_data", data_out, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single gap-free frame 0..7
        push_frame(0, 8);
        len_q.push_back(8);
        for (int k = 0; k < 8; k++) send(k);
        start_q.push_back(edge_cnt + 2);
        idle(12);

        // Three back-to-back frames 0..23: one 24-sample burst
        push_frame(0, 8);
        push_frame(8, 8);
        push_frame(16, 8);
        len_q.push_back(24);
        for (int k = 0; k < 24; k++) begin
            send(k);
            if (k == 7) start_q.push_back(edge_cnt + 2);
        end
        idle(30);

        // Frame with an idle cycle between every sample
        push_frame(0, 8);
        len_q.push_back(8);
        for (int k = 0; k < 8; k++) begin
            send(k);
            if (k == 7) start_q.push_back(edge_cnt + 2);
            idle(1);
        end
        idle(15);

        // Reset mid-input: the partial frame must vanish
        for (int k = 30; k < 35; k++) send(k);
        rst = 1'b1;
        #2;
        check("midframe_rst_valid", DW'(data_out_valid), '0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(100, 8);
        len_q.push_back(8);
        for (int k = 100; k < 108; k++) send(k);
        start_q.push_back(edge_cnt + 2);
        idle(15);

        // Reset during output: only the first 3 samples are seen
        push_frame(200, 3);
        len_q.push_back(3);
        for (int k = 200; k < 208; k++) send(k);
        start_q.push_back(edge_cnt + 2);
        idle(5);
        check("pre_rst_valid", DW'(data_out_valid), DW'(1));
        rst = 1'b1;
        #1;
        check("async_rst_valid", DW'(data_out_valid), '0);
        check("async_rst_data", data_out, '0);
`ifdef BITREV_FRAME_START_EN
        check("async_rst_sop", DW'(data_out_sop), '0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);

        // Bounded drain, then nothing may remain outstanding
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
        check("leftover_expected", DW'(exp_q.size()), '0);
        check("leftover_starts", DW'(start_q.size()), '0);
        check("leftover_lengths", DW'(len_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
